// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback controller.
package wb_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU,
    SRC_LD
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of ID, producer and register-file write signals for reg_writeback_ctrl.
// Forwarding signals exist only when REG_WB_FWD_EN is defined.
interface reg_writeback_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  import wb_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alloc_valid;
  logic [AW-1:0] alloc_rd;
  logic [AW-1:0] rs1_ID;
  logic [AW-1:0] rs2_ID;
  logic          stall_ID;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          Write_Enable_WB;
  logic [AW-1:0] rd_WB;
  logic [DW-1:0] Data_in_WB;
  logic [CW-1:0] q_count;
`ifdef REG_WB_FWD_EN
  logic          fwd1_valid;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_valid;
  logic [DW-1:0] fwd2_data;

  modport slave (
    input  alloc_valid, alloc_rd, rs1_ID, rs2_ID,
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output stall_ID, alu_ready, ld_ready, Write_Enable_WB, rd_WB, Data_in_WB, q_count,
    output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );
  modport master (
    output alloc_valid, alloc_rd, rs1_ID, rs2_ID,
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  stall_ID, alu_ready, ld_ready, Write_Enable_WB, rd_WB, Data_in_WB, q_count,
    input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
  );
`else
  modport slave (
    input  alloc_valid, alloc_rd, rs1_ID, rs2_ID,
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output stall_ID, alu_ready, ld_ready, Write_Enable_WB, rd_WB, Data_in_WB, q_count
  );
  modport master (
    output alloc_valid, alloc_rd, rs1_ID, rs2_ID,
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  stall_ID, alu_ready, ld_ready, Write_Enable_WB, rd_WB, Data_in_WB, q_count
  );
`endif

endinterface

// File: rtl/wb_entry_fifo.sv
// DEPTH-entry result FIFO: two ordered write ports (port 0 lands ahead of port 1),
// one read port, free count including the slot freed by this edge's pop.
module wb_entry_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push0,
  input  wb_entry_t                 data0,
  input  logic                      push1,
  input  wb_entry_t                 data1,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH):0]    free,
  output wb_entry_t [DEPTH-1:0]     entries,
  output logic [DEPTH-1:0]          entry_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         offset;

  // Next-state: pushes fill consecutive slots, pointers wrap modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push0) begin
      mem_d[wr_ptr_d] = data0;
      wr_ptr_d        = wr_ptr_d + PW'(1);
    end
    if (push1) begin
      mem_d[wr_ptr_d] = data1;
      wr_ptr_d        = wr_ptr_d + PW'(1);
    end
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy view: slot i is live if its distance from the head is below count.
  always_comb begin
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - rd_ptr_q;
      entry_valid[i] = CW'(offset) < count_q;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign free    = CW'(DEPTH) - count_q + CW'(count_q != '0);
  assign entries = mem_q;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: queues ALU/load results, writes one per cycle to the
// register file and keeps a per-register pending scoreboard that stalls ID.
// Optional macro REG_WB_FWD_EN adds forwarding of queued/in-flight results to ID.
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  reg_writeback_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_entry_t             alu_entry, ld_entry, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_valid;
  logic [CW-1:0]         count, free;
  logic                  pop, alu_acc, ld_acc, alloc_acc, stall;
  logic                  fwd1_hit, fwd2_hit;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  we_q;
  logic [AW-1:0]         rd_q;
  logic [DW-1:0]         data_q;

  assign alu_entry = {bus.alu_rd, bus.alu_data};
  assign ld_entry  = {bus.ld_rd, bus.ld_data};

  // Pop whenever the queue held something before this edge.
  assign pop = (count != '0);

  // A load alongside an ALU result needs room for both.
  assign bus.alu_ready = (free >= CW'(1));
  assign bus.ld_ready  = bus.alu_valid ? (free >= CW'(2)) : (free >= CW'(1));
  assign alu_acc       = bus.alu_valid & bus.alu_ready;
  assign ld_acc        = bus.ld_valid & bus.ld_ready;

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0       (alu_acc),
    .data0       (alu_entry),
    .push1       (ld_acc),
    .data1       (ld_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .free        (free),
    .entries     (entries),
    .entry_valid (entry_valid)
  );

`ifdef REG_WB_FWD_EN
  logic [DW-1:0] fwd1_data, fwd2_data;

  // Forward from the output register or any queued entry; at most one can match.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (we_q && rd_q == bus.rs1_ID) begin
      fwd1_hit  = 1'b1;
      fwd1_data = data_q;
    end
    if (we_q && rd_q == bus.rs2_ID) begin
      fwd2_hit  = 1'b1;
      fwd2_data = data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entries[i].rd == bus.rs1_ID) begin
        fwd1_hit  = 1'b1;
        fwd1_data = entries[i].data;
      end
      if (entry_valid[i] && entries[i].rd == bus.rs2_ID) begin
        fwd2_hit  = 1'b1;
        fwd2_data = entries[i].data;
      end
    end
  end

  assign bus.fwd1_valid = fwd1_hit;
  assign bus.fwd1_data  = fwd1_data;
  assign bus.fwd2_valid = fwd2_hit;
  assign bus.fwd2_data  = fwd2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{entries, entry_valid};
  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
`endif

  // RAW on either source (unless forwarded) or WAW on the destination holds ID.
  assign stall = (busy_q[bus.rs1_ID] & ~fwd1_hit) | (busy_q[bus.rs2_ID] & ~fwd2_hit) |
                 (bus.alloc_valid & busy_q[bus.alloc_rd]);
  assign bus.stall_ID = stall;
  assign alloc_acc    = bus.alloc_valid & ~stall;

  // Scoreboard update: clear on pop first so a same-index allocation wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (alloc_acc) busy_d[bus.alloc_rd] = 1'b1;
  end

  // Scoreboard and register-file write port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      we_q   <= pop;
      if (pop) begin
        rd_q   <= head.rd;
        data_q <= head.data;
      end
    end
  end

  assign bus.Write_Enable_WB = we_q;
  assign bus.rd_WB           = rd_q;
  assign bus.Data_in_WB      = data_q;
  assign bus.q_count         = count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios plus a randomized phase, all
// checked against a queue/set reference model of the writeback behaviour.
module tb_reg_writeback_ctrl;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  reg_writeback_ctrl_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: ordered list of accepted results, set of pending registers,
  // and the value currently presented to the register file.
  wb_entry_t       mq[$];
  logic [NREG-1:0] m_busy = '0;
  logic            m_we = 1'b0;
  logic [AW-1:0]   m_rd = '0;
  logic [DW-1:0]   m_data = '0;
  logic            acc_alu = 1'b0;
  logic            acc_ld = 1'b0;
  logic            acc_alloc = 1'b0;
  logic [AW-1:0]   outst[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free();
    return DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
  endfunction

  function automatic logic m_ld_rdy();
    return bus.alu_valid ? (m_free() >= 2) : (m_free() >= 1);
  endfunction

`ifdef REG_WB_FWD_EN
  function automatic logic m_hit(input logic [AW-1:0] r, output logic [DW-1:0] d);
    logic h;
    h = 1'b0;
    d = '0;
    if (m_we && m_rd == r) begin
      h = 1'b1;
      d = m_data;
    end
    foreach (mq[i]) if (mq[i].rd == r) begin
      h = 1'b1;
      d = mq[i].data;
    end
    return h;
  endfunction
`endif

  function automatic logic m_stall();
    logic h1, h2;
`ifdef REG_WB_FWD_EN
    logic [DW-1:0] d;
    h1 = m_hit(bus.rs1_ID, d);
    h2 = m_hit(bus.rs2_ID, d);
`else
    h1 = 1'b0;
    h2 = 1'b0;
`endif
    return (m_busy[bus.rs1_ID] & !h1) | (m_busy[bus.rs2_ID] & !h2) |
           (bus.alloc_valid & m_busy[bus.alloc_rd]);
  endfunction

  task automatic check_comb();
`ifdef REG_WB_FWD_EN
    logic [DW-1:0] d1, d2;
    logic h1, h2;
    h1 = m_hit(bus.rs1_ID, d1);
    h2 = m_hit(bus.rs2_ID, d2);
    check("fwd1_valid", bus.fwd1_valid, h1);
    check("fwd2_valid", bus.fwd2_valid, h2);
    if (h1) check("fwd1_data", bus.fwd1_data, d1);
    if (h2) check("fwd2_data", bus.fwd2_data, d2);
`endif
    check("stall_ID", bus.stall_ID, m_stall());
    check("alu_ready", bus.alu_ready, m_free() >= 1);
    check("ld_ready", bus.ld_ready, m_ld_rdy());
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge,
  // then check registered outputs just after it.
  task automatic cycle();
    wb_entry_t e;
    logic st;
    @(negedge clk);
    check_comb();
    st        = m_stall();
    acc_alu   = bus.alu_valid & (m_free() >= 1);
    acc_ld    = bus.ld_valid & m_ld_rdy();
    acc_alloc = bus.alloc_valid & !st;
    @(posedge clk);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1;
      m_rd = e.rd;
      m_data = e.data;
      m_busy[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (acc_alu) begin
      e.rd = bus.alu_rd;
      e.data = bus.alu_data;
      mq.push_back(e);
    end
    if (acc_ld) begin
      e.rd = bus.ld_rd;
      e.data = bus.ld_data;
      mq.push_back(e);
    end
    if (acc_alloc) m_busy[bus.alloc_rd] = 1'b1;
    #1;
    check("Write_Enable_WB", bus.Write_Enable_WB, m_we);
    check("rd_WB", bus.rd_WB, m_rd);
    check("Data_in_WB", bus.Data_in_WB, m_data);
    check("q_count", bus.q_count, mq.size());
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.rs1_ID      = '0;
    bus.rs2_ID      = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  initial begin
    int nxt;
    idle_inputs();
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", bus.Write_Enable_WB, 1'b0);
    check("rst_rd", bus.rd_WB, 4'd0);
    check("rst_data", bus.Data_in_WB, 16'd0);
    check("rst_qcount", bus.q_count, 3'd0);
    check("rst_stall", bus.stall_ID, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;

    // RAW: alloc r3, then ALU result r3 = 0x1234.
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 4'd3;
    cycle();
    bus.alloc_valid = 1'b0;
    bus.rs1_ID      = 4'd3;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 4'd3;
    bus.alu_data    = 16'h1234;
    #1 check("raw_stall_pre", bus.stall_ID, 1'b1);
    cycle();
    bus.alu_valid = 1'b0;
    #1 check("raw_stall_hold", bus.stall_ID, 1'b1);
    cycle();
    check("raw_we", bus.Write_Enable_WB, 1'b1);
    check("raw_rd", bus.rd_WB, 4'd3);
    check("raw_data", bus.Data_in_WB, 16'h1234);
    check("raw_stall_clr", bus.stall_ID, 1'b0);
    bus.rs1_ID = 4'd0;

    // Dual accept: ALU r1 ahead of load r2.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 4'd1;
    bus.alu_data  = 16'hAAAA;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 4'd2;
    bus.ld_data   = 16'h5555;
    #1 check("dual_alu_rdy", bus.alu_ready, 1'b1);
    check("dual_ld_rdy", bus.ld_ready, 1'b1);
    cycle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    cycle();
    check("dual_w1_rd", bus.rd_WB, 4'd1);
    check("dual_w1_data", bus.Data_in_WB, 16'hAAAA);
    cycle();
    check("dual_w2_rd", bus.rd_WB, 4'd2);
    check("dual_w2_data", bus.Data_in_WB, 16'h5555);
    cycle();
    check("dual_idle_we", bus.Write_Enable_WB, 1'b0);
    check("dual_hold_data", bus.Data_in_WB, 16'h5555);

    // Fill to DEPTH with a continuous two-producer stream.
    nxt = 0;
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    bus.alu_rd    = AW'(8 + (nxt & 7));
    bus.alu_data  = 16'h0A00 + 16'(nxt);
    nxt++;
    bus.ld_rd     = AW'(8 + (nxt & 7));
    bus.ld_data   = 16'h0B00 + 16'(nxt);
    nxt++;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (acc_alu) begin
        bus.alu_rd   = AW'(8 + (nxt & 7));
        bus.alu_data = 16'h0A00 + 16'(nxt);
        nxt++;
      end
      if (acc_ld) begin
        bus.ld_rd   = AW'(8 + (nxt & 7));
        bus.ld_data = 16'h0B00 + 16'(nxt);
        nxt++;
      end
    end
    #1 check("full_qcount", bus.q_count, 3'd4);
    check("full_alu_rdy", bus.alu_ready, 1'b1);
    check("full_ld_rdy", bus.ld_ready, 1'b0);
    cycle();
    check("full_qcount2", bus.q_count, 3'd4);
    bus.alu_valid = 1'b0;
    #1 check("full_ld_alone", bus.ld_ready, 1'b1);
    cycle();
    bus.ld_valid = 1'b0;
    repeat (6) cycle();

    // Randomized traffic with allocation-consistent producers.
    acc_alu = 1'b0;
    acc_ld  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!bus.alu_valid || acc_alu) begin
        if (outst.size() > 0 && $urandom_range(1, 0) == 1) begin
          bus.alu_valid = 1'b1;
          bus.alu_rd    = outst.pop_front();
          bus.alu_data  = DW'($urandom);
        end else begin
          bus.alu_valid = 1'b0;
        end
      end
      if (!bus.ld_valid || acc_ld) begin
        if (outst.size() > 0 && $urandom_range(1, 0) == 1) begin
          bus.ld_valid = 1'b1;
          bus.ld_rd    = outst.pop_front();
          bus.ld_data  = DW'($urandom);
        end else begin
          bus.ld_valid = 1'b0;
        end
      end
      bus.alloc_valid = ($urandom_range(2, 0) != 0);
      bus.alloc_rd    = AW'($urandom);
      bus.rs1_ID      = AW'($urandom);
      bus.rs2_ID      = AW'($urandom);
      cycle();
      if (acc_alloc) outst.push_back(bus.alloc_rd);
    end
    bus.alloc_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (acc_alu) bus.alu_valid = 1'b0;
      if (acc_ld) bus.ld_valid = 1'b0;
    end
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    repeat (6) cycle();

    // Reset mid-queue with three entries.
    bus.rs1_ID = 4'd0;
    bus.rs2_ID = 4'd0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 4'd10;
    bus.alu_data  = 16'h0010;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 4'd11;
    bus.ld_data   = 16'h0011;
    cycle();
    bus.alu_rd    = 4'd12;
    bus.ld_rd     = 4'd13;
    cycle();
    idle_inputs();
    bus.rs1_ID = 4'd5;
    #1 check("mid_qcount_pre", bus.q_count, 3'd3);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check("mid_qcount", bus.q_count, 3'd0);
    check("mid_we", bus.Write_Enable_WB, 1'b0);
    check("mid_stall", bus.stall_ID, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("post_rst_rs5", bus.stall_ID, 1'b0);

    // WAW hold on r7, then same-edge pop of r7 with a new alloc of r7.
    bus.rs1_ID = 4'd0;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 4'd7;
    cycle();
    #1 check("waw_stall", bus.stall_ID, 1'b1);
    cycle();
    bus.alloc_valid = 1'b0;
    bus.rs1_ID      = 4'd7;
    #1 check("waw_busy_kept", bus.stall_ID, 1'b1);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 4'd7;
    bus.alu_data  = 16'h0777;
    cycle();
    bus.alu_valid = 1'b0;
    cycle();
    #1 check("r7_cleared", bus.stall_ID, 1'b0);
    bus.rs1_ID    = 4'd0;
    bus.alu_valid = 1'b1;
    bus.alu_data  = 16'h7777;
    cycle();
    bus.alu_valid   = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 4'd7;
    #1 check("set_clr_nostall", bus.stall_ID, 1'b0);
    cycle();
    bus.alloc_valid = 1'b0;
    bus.rs1_ID      = 4'd7;
    #1 check("set_wins", bus.stall_ID, 1'b1);
    check("set_clr_wb_rd", bus.rd_WB, 4'd7);
    check("set_clr_wb_data", bus.Data_in_WB, 16'h7777);
    bus.rs1_ID = 4'd0;
    cycle();

`ifdef REG_WB_FWD_EN
    // Forward a queued r4 to source 2.
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 4'd4;
    cycle();
    bus.alloc_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 4'd4;
    bus.alu_data    = 16'hBEEF;
    cycle();
    bus.alu_valid = 1'b0;
    bus.rs2_ID    = 4'd4;
    #1 check("fwd2_valid_q", bus.fwd2_valid, 1'b1);
    check("fwd2_data_q", bus.fwd2_data, 16'hBEEF);
    check("fwd_nostall", bus.stall_ID, 1'b0);
    cycle();
    bus.rs2_ID = 4'd0;
    repeat (2) cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
